// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - 2-bit counter branch predictor with EX resolution and redirect/flush sequencing
// Optional statistics counters enabled by defining BRANCH_STATS_EN.
module branch_predict_ctrl #(
    parameter int IDX_W     = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    input  logic        i_ex_valid,
    input  logic        i_ex_branch,
    input  logic [2:0]  i_ex_func3,
    input  logic        i_ex_zero,
    input  logic        i_ex_neg,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] o_stat_branches,
    output logic [31:0] o_stat_mispredicts
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t               r_state;
    logic [3:0]           r_flush_cnt;
    logic [2*DEPTH-1:0]   r_table;

    logic [IDX_W-1:0]     w_if_idx;
    logic [IDX_W-1:0]     w_ex_idx;
    logic [1:0]           w_ex_cnt;
    logic [1:0]           w_next_cnt;
    logic                 w_actual;
    logic                 w_resolve;
    logic                 w_mispredict;
    logic                 w_unused_if_pc;

    assign w_if_idx       = i_if_pc[IDX_W+1:2];
    assign w_ex_idx       = i_ex_pc[IDX_W+1:2];
    assign w_unused_if_pc = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

    // Counters are packed two bits per entry so reset and indexing stay single-driver.
    assign o_pred_taken = r_table[{w_if_idx, 1'b1}];
    assign w_ex_cnt     = r_table[{w_ex_idx, 1'b0} +: 2];

    always_comb begin
        w_actual = 1'b0;
        case (i_ex_func3[1:0])
            2'b00: w_actual = i_ex_zero;
            2'b01: w_actual = ~i_ex_zero;
            2'b10: w_actual = i_ex_neg;
            2'b11: w_actual = i_ex_zero | ~i_ex_neg;
        endcase
    end

    always_comb begin
        w_next_cnt = w_ex_cnt;
        if (w_actual && w_ex_cnt != 2'b11)
            w_next_cnt = w_ex_cnt + 2'd1;
        else if (!w_actual && w_ex_cnt != 2'b00)
            w_next_cnt = w_ex_cnt - 2'd1;
    end

    // Wrong-path instructions arrive while flushing, so resolution is gated on IDLE.
    assign w_resolve    = i_ex_valid & i_ex_branch & ~i_ex_func3[2] & (r_state == ST_IDLE);
    assign w_mispredict = w_resolve & (w_actual != i_ex_pred_taken);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_table <= {DEPTH{2'b01}};
        end else if (w_resolve) begin
            r_table[{w_ex_idx, 1'b0} +: 2] <= w_next_cnt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_flush_cnt   <= 4'd0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= 32'd0;
            o_flush       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mispredict) begin
                        r_state       <= ST_FLUSH;
                        o_redirect    <= 1'b1;
                        o_redirect_pc <= w_actual ? i_ex_target : i_ex_pc + 32'd4;
                        o_flush       <= 1'b1;
                        r_flush_cnt   <= 4'(FLUSH_CYC - 1);
                    end
                end
                ST_FLUSH: begin
                    o_redirect <= 1'b0;
                    if (r_flush_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                        o_flush <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stat_branches    <= 32'd0;
            o_stat_mispredicts <= 32'd0;
        end else begin
            if (w_resolve)
                o_stat_branches <= o_stat_branches + 32'd1;
            if (w_mispredict)
                o_stat_mispredicts <= o_stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - directed bench for branch_predict_ctrl with a per-cycle reference model
module tb_branch_predict_ctrl;

    localparam int IDX_W     = 4;
    localparam int FLUSH_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_branch = 1'b0;
    logic [2:0]  ex_func3 = 3'd0;
    logic        ex_zero = 1'b0;
    logic        ex_neg = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic [31:0] ex_target = 32'd0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.IDX_W(IDX_W), .FLUSH_CYC(FLUSH_CYC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc), .o_pred_taken(pred_taken),
        .i_ex_valid(ex_valid), .i_ex_branch(ex_branch), .i_ex_func3(ex_func3),
        .i_ex_zero(ex_zero), .i_ex_neg(ex_neg), .i_ex_pred_taken(ex_pred_taken),
        .i_ex_pc(ex_pc), .i_ex_target(ex_target),
        .o_redirect(redirect), .o_redirect_pc(redirect_pc), .o_flush(flush)
`ifdef BRANCH_STATS_EN
        , .o_stat_branches(stat_branches), .o_stat_mispredicts(stat_mispredicts)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table of counters, remaining flush cycles, last redirect.
    int          m_tab [1 << IDX_W];
    int          m_fl;
    bit          m_red;
    logic [31:0] m_rpc;

    function automatic bit outcome(input logic [2:0] f3, input logic z, input logic n);
        case (f3[1:0])
            2'd0:    return z;
            2'd1:    return !z;
            2'd2:    return n;
            default: return z || !n;
        endcase
    endfunction

    always @(posedge clk) begin
        bit res;
        bit act;
        int i;
        if (!rst_n) begin
            foreach (m_tab[k]) m_tab[k] <= 1;
            m_fl  <= 0;
            m_red <= 0;
            m_rpc <= 32'd0;
        end else begin
            res = ex_valid && ex_branch && (ex_func3 <= 3'd3) && (m_fl == 0);
            act = outcome(ex_func3, ex_zero, ex_neg);
            i   = int'(ex_pc[IDX_W+1:2]);
            m_red <= 0;
            if (m_fl > 0) m_fl <= m_fl - 1;
            if (res) begin
                if (act) m_tab[i] <= (m_tab[i] == 3) ? 3 : m_tab[i] + 1;
                else     m_tab[i] <= (m_tab[i] == 0) ? 0 : m_tab[i] - 1;
                if (act != ex_pred_taken) begin
                    m_red <= 1;
                    m_rpc <= act ? ex_target : ex_pc + 32'd4;
                    m_fl  <= FLUSH_CYC;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, m_tab[int'(if_pc[IDX_W+1:2])] >= 2});
            chk("model_redirect", {31'd0, redirect}, {31'd0, m_red});
            chk("model_redirect_pc", redirect_pc, m_rpc);
            chk("model_flush", {31'd0, flush}, {31'd0, m_fl > 0});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [2:0] f3, input logic z, input logic n, input logic p,
                      input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_func3 = f3;
        ex_zero = z; ex_neg = n; ex_pred_taken = p; ex_pc = pc; ex_target = tgt;
        step();
        ex_valid = 1'b0; ex_branch = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h40;
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset_redirect", {31'd0, redirect}, 32'd0);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        step();

        // BEQ taken, predicted not-taken
        br(3'b000, 1, 0, 0, 32'h40, 32'h80);
        chk("beq_redirect_t1", {31'd0, redirect}, 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h80);
        chk("beq_flush_t1", {31'd0, flush}, 32'd1);
        chk("beq_pred_after_train", {31'd0, pred_taken}, 32'd1);
        step();
        chk("beq_redirect_t2", {31'd0, redirect}, 32'd0);
        chk("beq_flush_t2", {31'd0, flush}, 32'd1);
        step();
        chk("beq_flush_t3", {31'd0, flush}, 32'd0);

        // Three correct taken predictions saturate the counter
        for (int k = 0; k < 3; k++) begin
            br(3'b000, 1, 0, 1, 32'h40, 32'h80);
            chk("beq_correct_redirect", {31'd0, redirect}, 32'd0);
            chk("beq_correct_flush", {31'd0, flush}, 32'd0);
        end

        // BNE not-taken while predicted taken: 11 -> 10
        br(3'b001, 1, 0, 1, 32'h40, 32'h80);
        chk("bne_redirect", {31'd0, redirect}, 32'd1);
        chk("bne_redirect_pc", redirect_pc, 32'h44);
        step(); step();
        chk("bne_pred_still_taken", {31'd0, pred_taken}, 32'd1);

        // BLT not-taken mispredict, then wrong-path BGE mispredicts during flush
        br(3'b010, 0, 0, 1, 32'h10, 32'h90);
        chk("blt_redirect_pc", redirect_pc, 32'h14);
        br(3'b011, 0, 0, 0, 32'h20, 32'h300);
        br(3'b011, 0, 0, 0, 32'h20, 32'h300);
        chk("flush_ignore_redirect", {31'd0, redirect}, 32'd0);
        chk("flush_ignore_flush", {31'd0, flush}, 32'd0);
        chk("flush_ignore_rpc", redirect_pc, 32'h14);
        if_pc = 32'h20;
        #1;
        chk("flush_ignore_pred", {31'd0, pred_taken}, 32'd0);

        // Reserved func3 must neither redirect nor train
        br(3'b110, 1, 0, 0, 32'h24, 32'h400);
        if_pc = 32'h24;
        #1;
        chk("func3_110_redirect", {31'd0, redirect}, 32'd0);
        chk("func3_110_pred", {31'd0, pred_taken}, 32'd0);

        // Assorted outcomes checked by the model only
        br(3'b010, 0, 1, 0, 32'h30, 32'h200); step(); step();
        br(3'b011, 0, 1, 1, 32'h34, 32'h204); step(); step();
        br(3'b011, 1, 1, 1, 32'h38, 32'h208);
        br(3'b001, 0, 0, 1, 32'h3C, 32'h20C);

        // Fall-through at the top of the address space wraps
        br(3'b000, 0, 0, 1, 32'hFFFFFFFC, 32'h100);
        chk("wrap_redirect", {31'd0, redirect}, 32'd1);
        chk("wrap_redirect_pc", redirect_pc, 32'h0);

        // Reset mid-flush
        if_pc = 32'h40;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midflush_rst_flush", {31'd0, flush}, 32'd0);
        chk("midflush_rst_redirect", {31'd0, redirect}, 32'd0);
        chk("midflush_rst_rpc", redirect_pc, 32'h0);
        chk("midflush_rst_pred", {31'd0, pred_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("midflush_rst_stat_br", stat_branches, 32'd0);
        chk("midflush_rst_stat_mp", stat_mispredicts, 32'd0);
`endif
        step(); step();
        rst_n = 1'b1;
        step();
        chk("post_rst_flush", {31'd0, flush}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch prediction and resolution controller for the pipelined RISC-V core.
- Holds a direct-mapped table of 2-bit saturating counters and supplies a taken/not-taken prediction to IF.
- Resolves EX-stage branches (BEQ/BNE/BLT/BGE) from ALU zero/neg flags, trains the table, and sequences the redirect/flush of wrong-path instructions after a mispredict.

Parameters:
IDX_W, 4, table index width; 2^IDX_W counters indexed by pc[IDX_W+1:2]
FLUSH_CYC, 2, cycles flush stays high after a mispredict (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_pc  in  32  PC of the fetching instruction
pred_taken  out  1  prediction for if_pc
ex_valid  in  1  EX holds a live instruction
ex_branch  in  1  EX instruction is a conditional branch
ex_func3  in  3  branch func3: 000 BEQ, 001 BNE, 010 BLT, 011 BGE
ex_zero  in  1  ALU zero flag
ex_neg  in  1  ALU negative flag
ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction
ex_pc  in  32  PC of the EX instruction
ex_target  in  32  branch target computed in EX
redirect  out  1  one-cycle pulse: fetch from redirect_pc
redirect_pc  out  32  corrected fetch address
flush  out  1  squash IF/ID and ID/EX contents

Behaviour:
- Reset (async, rst_n=0): all counters = 2'b01 (weakly not-taken); state IDLE; redirect=0, redirect_pc=0, flush=0. Holds while rst_n low. Reset mid-FLUSH aborts the flush immediately.
- pred_taken: combinational, counter[idx(if_pc)][1]. No write-to-read bypass; same-cycle update is visible the next cycle.
- Resolution (combinational, cycle t): resolve = ex_valid & ex_branch & (ex_func3 <= 3'b011) & (state == IDLE).
  - Actual outcome: BEQ zero; BNE ~zero; BLT neg; BGE zero | ~neg.
  - func3 100..111 => resolve=0: no update, no redirect.
- mispredict = resolve & (actual != ex_pred_taken).
- Training (edge ending t, when resolve=1): counter[idx(ex_pc)] +1 if taken, -1 if not. Saturates at 2'b11 and 2'b00.
- FSM:
  - IDLE: mispredict -> FLUSH. On that edge: redirect<=1; redirect_pc <= actual ? ex_target : ex_pc+4 (mod 2^32); flush<=1; flush counter <= FLUSH_CYC-1.
  - FLUSH:
    - redirect forced 0 after its first cycle.
    - flush stays 1; counter decrements each cycle.
    - EX inputs ignored: no training, no nested mispredict.
    - Counter==0 -> IDLE with flush<=0 on the same edge.
- Latency: mispredict in cycle t -> redirect high exactly cycle t+1; flush high cycles t+1 .. t+FLUSH_CYC.
- Correct predictions: no redirect/flush; training only.
- Back-to-back mispredicts: the second is ignored if it arrives while in FLUSH, because it is wrong-path.
- Aliasing: PCs sharing pc[IDX_W+1:2] share a counter; no tags.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Reset to 0 asynchronously.
  - +1 on each resolve / mispredict edge respectively.
  - Wrap at 2^32.
- Not defined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset, then if_pc=0x00000040 -> pred_taken=0; redirect=0, flush=0.
- BEQ at ex_pc=0x40, zero=1, ex_pred_taken=0:
  - Next cycle redirect=1 for exactly 1 cycle, redirect_pc=ex_target=0x80.
  - flush=1 for 2 cycles.
  - Counter[0x40] becomes 10, so pred_taken=1 for if_pc=0x40.
- Three more taken BEQ at 0x40 with correct predictions:
  - Counter saturates at 11; no redirect/flush.
  - Then BNE with zero=1, pred=1: redirect_pc=0x44, counter=10.
- BLT ex_pc=0x10, neg=0, pred=1: redirect_pc=0x14. During the 2 flush cycles, drive a mispredicting BGE at ex_pc=0x20 -> ignored, counter[0x20] unchanged (pred_taken for if_pc=0x20 stays 0).
- func3=3'b110 with ex_branch=1 -> no redirect, no table change. ex_pc=0xFFFFFFFC not-taken mispredict -> redirect_pc=0x00000000.
- Assert rst_n=0 in the middle of a FLUSH -> flush and redirect drop immediately, table returns to 01; with BRANCH_STATS_EN defined, both stats read 0.
